// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer:
// opcodes, immediate-select and ALU-select codes, and the FSM state type.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_U = 2'b10;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction decoder: maps an RV32I word to datapath
// control fields and instruction-class flags.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic [1:0]  imm_sel,
  output logic        bsel,
  output logic [3:0]  alu_sel,
  output logic        wb_sel,
  output logic        is_load,
  output logic        is_store,
  output logic        writes_rd,
  output logic        is_sys,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_inst_bits;

  assign opcode           = inst[6:0];
  assign funct3           = inst[14:12];
  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    imm_sel   = IMM_I;
    bsel      = 1'b0;
    alu_sel   = ALU_ADD;
    wb_sel    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    writes_rd = 1'b0;
    is_sys    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_sel   = {inst[30], funct3};
        wb_sel    = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        // inst[30] is part of the immediate except for the shift-right pair
        alu_sel   = {(funct3 == F3_SR) ? inst[30] : 1'b0, funct3};
        bsel      = 1'b1;
        wb_sel    = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_LUI: begin
        imm_sel   = IMM_U;
        alu_sel   = ALU_PASSB;
        bsel      = 1'b1;
        wb_sel    = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        if (funct3 == F3_WORD) begin
          bsel      = 1'b1;
          is_load   = 1'b1;
          writes_rd = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_WORD) begin
          imm_sel  = IMM_S;
          bsel     = 1'b1;
          is_store = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_SYSTEM: is_sys = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: PC, instruction fetch handshake,
// registered decode and per-state write strobes. Optional performance
// counters are enabled by defining RISCV_CTRL_PERF_EN.
module riscv_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [1:0]  ImmSel,
  output logic        RegWEn,
  output logic        Bsel,
  output logic [3:0]  ALUSel,
  output logic        MemRW,
  output logic        WBSel,
  output logic        halted,
  output logic        trap,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic        req_q, req_d, fetch_en_q;
  logic [1:0]  imm_sel_q, imm_sel_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic        bsel_q, bsel_d, wb_sel_q, wb_sel_d;
  logic        is_load_q, is_load_d, is_store_q, is_store_d;
  logic        writes_rd_q, writes_rd_d;
  logic        halted_q, halted_d, trap_q, trap_d;

  logic [1:0]  dec_imm_sel;
  logic [3:0]  dec_alu_sel;
  logic        dec_bsel, dec_wb_sel, dec_is_load, dec_is_store;
  logic        dec_writes_rd, dec_is_sys, dec_illegal;

  riscv_ctrl_decode u_decode (
    .inst      (inst_q),
    .imm_sel   (dec_imm_sel),
    .bsel      (dec_bsel),
    .alu_sel   (dec_alu_sel),
    .wb_sel    (dec_wb_sel),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .writes_rd (dec_writes_rd),
    .is_sys    (dec_is_sys),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      req_q       <= 1'b0;
      fetch_en_q  <= 1'b0;
      imm_sel_q   <= IMM_I;
      alu_sel_q   <= ALU_ADD;
      bsel_q      <= 1'b0;
      wb_sel_q    <= 1'b0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      writes_rd_q <= 1'b0;
      halted_q    <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      req_q       <= req_d;
      fetch_en_q  <= 1'b1;
      imm_sel_q   <= imm_sel_d;
      alu_sel_q   <= alu_sel_d;
      bsel_q      <= bsel_d;
      wb_sel_q    <= wb_sel_d;
      is_load_q   <= is_load_d;
      is_store_q  <= is_store_d;
      writes_rd_q <= writes_rd_d;
      halted_q    <= halted_d;
      trap_q      <= trap_d;
    end
  end

  // run only opens a request; once raised, req_q keeps it up until the ack.
  // fetch_en_q holds the request off during the reset-release cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    req_d       = 1'b0;
    imm_sel_d   = imm_sel_q;
    alu_sel_d   = alu_sel_q;
    bsel_d      = bsel_q;
    wb_sel_d    = wb_sel_q;
    is_load_d   = is_load_q;
    is_store_d  = is_store_q;
    writes_rd_d = writes_rd_q;
    halted_d    = halted_q;
    trap_d      = trap_q;
    imem_req    = 1'b0;
    RegWEn      = 1'b0;
    MemRW       = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = req_q || (run && fetch_en_q);
        req_d    = imem_req && !imem_ack;
        if (imem_req && imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_sel_d   = dec_imm_sel;
        alu_sel_d   = dec_alu_sel;
        bsel_d      = dec_bsel;
        wb_sel_d    = dec_wb_sel;
        is_load_d   = dec_is_load;
        is_store_d  = dec_is_store;
        writes_rd_d = dec_writes_rd;
        if (dec_illegal) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          trap_d   = 1'b1;
        end else if (dec_is_sys) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        RegWEn = writes_rd_q && !is_load_q;
        MemRW  = is_store_q;
        if (is_load_q) begin
          state_d = S_MEM;
        end else begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        RegWEn  = 1'b1;
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  assign pc     = pc_q;
  assign inst   = inst_q;
  assign ImmSel = imm_sel_q;
  assign Bsel   = bsel_q;
  assign ALUSel = alu_sel_q;
  assign WBSel  = wb_sel_q;
  assign halted = halted_q;
  assign trap   = trap_q;

`ifdef RISCV_CTRL_PERF_EN
  logic [31:0] cycle_q, instret_q;
  logic        retire;

  assign retire = ((state_q == S_EXEC) && !is_load_q) || (state_q == S_MEM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (!halted_q) cycle_q <= cycle_q + 32'd1;
      if (retire)    instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Directed self-checking bench for riscv_ctrl_fsm: reset, fetch handshake,
// ALU/LUI/store/load sequencing, halt and trap behaviour.
module tb_riscv_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] pc, inst;
  logic [1:0]  ImmSel;
  logic        RegWEn, Bsel, MemRW, WBSel, halted, trap;
  logic [3:0]  ALUSel;
  logic [31:0] cycle_cnt, instret_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] saved_cycles;

  riscv_ctrl_fsm #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .pc          (pc),
    .inst        (inst),
    .ImmSel      (ImmSel),
    .RegWEn      (RegWEn),
    .Bsel        (Bsel),
    .ALUSel      (ALUSel),
    .MemRW       (MemRW),
    .WBSel       (WBSel),
    .halted      (halted),
    .trap        (trap),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_instret(input string tag, input logic [31:0] exp);
`ifdef RISCV_CTRL_PERF_EN
    chk(tag, instret_cnt, exp);
`else
    chk(tag, instret_cnt, 32'h0);
`endif
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    tick(); tick();
    // reset state
    chk("rst_pc", pc, 32'h100);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_regwen", {31'b0, RegWEn}, 32'h0);
    chk("rst_memrw", {31'b0, MemRW}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_alusel", {28'b0, ALUSel}, 32'h0);
    chk("rst_flags", {30'b0, halted, trap}, 32'h0);
    chk("rst_cycle", cycle_cnt, 32'h0);
    rst = 1'b0;
    chk("rel_req_same_cycle", {31'b0, imem_req}, 32'h0);
    tick();
    chk("rel_req_next", {31'b0, imem_req}, 32'h1);

    // addi x1,x0,5 with two wait cycles; run drops while request outstanding
    tick();
    run = 1'b0;
    chk("wait1_req_held", {31'b0, imem_req}, 32'h1);
    tick();
    chk("wait2_req_held", {31'b0, imem_req}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0; run = 1'b1;
    chk("addi_dec_inst", inst, 32'h0050_0093);
    chk("addi_dec_req", {31'b0, imem_req}, 32'h0);
    chk("addi_dec_regwen", {31'b0, RegWEn}, 32'h0);
    tick();
    chk("addi_ex_immsel", {30'b0, ImmSel}, 32'h0);
    chk("addi_ex_bsel", {31'b0, Bsel}, 32'h1);
    chk("addi_ex_alusel", {28'b0, ALUSel}, 32'h0);
    chk("addi_ex_wbsel", {31'b0, WBSel}, 32'h1);
    chk("addi_ex_regwen", {31'b0, RegWEn}, 32'h1);
    chk("addi_ex_pc", pc, 32'h100);
    tick();
    chk("addi_f_regwen", {31'b0, RegWEn}, 32'h0);
    chk("addi_f_pc", pc, 32'h104);
    chk("addi_f_req", {31'b0, imem_req}, 32'h1);
    chk_instret("addi_instret", 32'd1);

    // sub x3,x1,x2
    imem_ack = 1'b1; imem_rdata = 32'h4020_81B3;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("sub_ex_alusel", {28'b0, ALUSel}, 32'h8);
    chk("sub_ex_bsel", {31'b0, Bsel}, 32'h0);
    chk("sub_ex_regwen", {31'b0, RegWEn}, 32'h1);
    chk("sub_ex_memrw", {31'b0, MemRW}, 32'h0);
    tick();
    chk("sub_f_regwen", {31'b0, RegWEn}, 32'h0);
    chk("sub_f_pc", pc, 32'h108);

    // ack without a request is ignored
    run = 1'b0;
    #1;
    chk("idle_req", {31'b0, imem_req}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("stray_ack_inst", inst, 32'h4020_81B3);
    chk("stray_ack_req", {31'b0, imem_req}, 32'h0);
    run = 1'b1;
    #1;
    chk("run_req", {31'b0, imem_req}, 32'h1);

    // sw x2,8(x1)
    imem_ack = 1'b1; imem_rdata = 32'h0020_A423;
    tick();
    imem_ack = 1'b0;
    chk("sw_dec_strobes", {30'b0, RegWEn, MemRW}, 32'h0);
    tick();
    chk("sw_ex_immsel", {30'b0, ImmSel}, 32'h1);
    chk("sw_ex_bsel", {31'b0, Bsel}, 32'h1);
    chk("sw_ex_memrw", {31'b0, MemRW}, 32'h1);
    chk("sw_ex_regwen", {31'b0, RegWEn}, 32'h0);
    tick();
    chk("sw_f_memrw", {31'b0, MemRW}, 32'h0);
    chk("sw_f_pc", pc, 32'h10C);

    // lw x5,4(x1): new request 4 cycles after ack
    imem_ack = 1'b1; imem_rdata = 32'h0040_A283;
    tick();
    imem_ack = 1'b0;
    chk("lw_c1_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("lw_ex_regwen", {31'b0, RegWEn}, 32'h0);
    chk("lw_ex_bsel", {31'b0, Bsel}, 32'h1);
    chk("lw_ex_alusel", {28'b0, ALUSel}, 32'h0);
    chk("lw_ex_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("lw_mem_regwen", {31'b0, RegWEn}, 32'h1);
    chk("lw_mem_wbsel", {31'b0, WBSel}, 32'h0);
    chk("lw_mem_req", {31'b0, imem_req}, 32'h0);
    chk("lw_mem_pc", pc, 32'h10C);
    tick();
    chk("lw_c4_req", {31'b0, imem_req}, 32'h1);
    chk("lw_c4_regwen", {31'b0, RegWEn}, 32'h0);
    chk("lw_c4_pc", pc, 32'h110);
    chk_instret("lw_instret", 32'd4);

    // lui x1,0x12345
    imem_ack = 1'b1; imem_rdata = 32'h1234_50B7;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("lui_ex_immsel", {30'b0, ImmSel}, 32'h2);
    chk("lui_ex_alusel", {28'b0, ALUSel}, 32'hF);
    chk("lui_ex_regwen", {31'b0, RegWEn}, 32'h1);
    tick();
    chk("lui_f_pc", pc, 32'h114);

    // illegal all-zero word -> trap
    imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("ill_flags", {30'b0, halted, trap}, 32'h3);
    chk("ill_pc", pc, 32'h114);
    chk("ill_regwen", {31'b0, RegWEn}, 32'h0);
    chk_instret("ill_instret", 32'd5);
    saved_cycles = cycle_cnt;
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick(); tick();
    imem_ack = 1'b0;
    tick();
    chk("halt_req", {31'b0, imem_req}, 32'h0);
    chk("halt_pc", pc, 32'h114);
    chk("halt_flags_sticky", {30'b0, halted, trap}, 32'h3);
    chk("halt_cycle_frozen", cycle_cnt, saved_cycles);

    // asynchronous reset out of HALT, then ecall -> halt without trap
    #2 rst = 1'b1;
    #1;
    chk("rst2_pc", pc, 32'h100);
    chk("rst2_flags", {30'b0, halted, trap}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst2_req", {31'b0, imem_req}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("ecall_flags", {30'b0, halted, trap}, 32'h2);
    chk("ecall_pc", pc, 32'h100);
    chk_instret("ecall_instret", 32'd0);
    tick();
    chk("ecall_req", {31'b0, imem_req}, 32'h0);

    // lb (funct3=000) is not supported -> trap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h0000_8283;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("lb_flags", {30'b0, halted, trap}, 32'h3);
    chk("lb_pc", pc, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_ctrl_fsm.md
# riscv_ctrl_fsm

Multi-cycle control sequencer for the RV32I datapath. It owns the program counter and fetches each instruction from instruction memory over a req/ack handshake, then holds it on `inst`. It decodes the held instruction and drives the datapath control lines (`ImmSel`, `RegWEn`, `Bsel`, `ALUSel`, `MemRW`, `WBSel`) one state at a time. Register-file and data-memory write strobes are confined to single, well-defined cycles.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  allows a new fetch to start; sampled only in FETCH before `imem_req` is raised.
- `imem_ack`  in  1  instruction memory ack; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `imem_req`  out  1  fetch request.
- `pc`  out  32  current PC; also the fetch address.
- `inst`  out  32  latched instruction, fed to the datapath.
- `ImmSel`  out  2  00=I, 01=S, 10=U.
- `RegWEn`  out  1  register-file write enable.
- `Bsel`  out  1  0=rs2 data, 1=immediate.
- `ALUSel`  out  4  ALU operation.
- `MemRW`  out  1  1=data-memory write.
- `WBSel`  out  1  0=memory read data, 1=ALU result.
- `halted`  out  1  sticky; no further fetches.
- `trap`  out  1  sticky; set on illegal instruction.
- `cycle_cnt`, `instret_cnt`  out  32 each  performance counters (see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, MEM, HALT.
- **FETCH**
  - With `run`=1 and not halted: raise `imem_req` and hold it until `imem_ack`.
  - On ack: latch `inst`<=`imem_rdata`, then go to DECODE.
  - `imem_ack` while `imem_req`=0 is ignored.
- **DECODE:** register the control fields from `inst[6:0]`, funct3 and `inst[30]`.
- **ALUSel** = {b3, funct3}:
  - R-type: b3=`inst[30]`.
  - OP-IMM: b3=`inst[30]` only when funct3=101, else 0.
  - Loads, stores: 0000 (ADD).
  - LUI: 1111 (PASSB).
- **Per-opcode controls**
  - OP (0110011): Bsel=0, WBSel=1, write in EXEC.
  - OP-IMM (0010011): ImmSel=00, Bsel=1, WBSel=1, write in EXEC.
  - LUI (0110111): ImmSel=10, Bsel=1, WBSel=1, write in EXEC.
  - LOAD (0000011), funct3=010 only: ImmSel=00, Bsel=1. EXEC has RegWEn=0; MEM has RegWEn=1, WBSel=0.
  - STORE (0100011), funct3=010 only: ImmSel=01, Bsel=1. MemRW=1 in EXEC only.
  - SYSTEM (1110011): enter HALT with `halted`=1, `trap`=0.
  - Any other opcode, or a LOAD/STORE funct3 other than 010: enter HALT with `halted`=1, `trap`=1.
- **After EXEC** (or after MEM for loads): `pc`<=`pc`+4 with 32-bit wrap (FFFF_FFFC→0000_0000), then FETCH.
- **Write-strobe gating:** `RegWEn`=0 and `MemRW`=0 in every state except the EXEC/MEM cycle named above. Other control outputs keep their last decoded value.
- **HALT:** absorbing; only `rst` exits. `pc` is left at the halting instruction's address.

## Timing
- **Reset values** (`rst` asserted):
  - `pc`=`RESET_PC`, `inst`=0, `imem_req`=0.
  - `ImmSel`=00, `RegWEn`=0, `Bsel`=0, `ALUSel`=0000, `MemRW`=0, `WBSel`=0.
  - `halted`=0, `trap`=0, counters=0.
  - State=FETCH.
- **Reset mid-fetch:** `imem_req` drops asynchronously. Any ack arriving after that is ignored.
- **Latency from the ack cycle:**
  - ALU/LUI/store: 3 cycles (DECODE, EXEC, FETCH with the new `pc`).
  - Load: 4 cycles.
  - Earliest new `imem_req`: the cycle after EXEC (or after MEM for loads).
- **run:** `run`=0 while `imem_req`=1 does not cancel the outstanding request.

## Configuration
- Macro `RISCV_CTRL_PERF_EN`.
- **Defined:**
  - `cycle_cnt` increments every cycle while not halted.
  - `instret_cnt` increments on each EXEC→FETCH or MEM→FETCH transition.
  - Both wrap at 2^32.
- **Undefined:** both ports are present but tied to 0, and no counter flops are inferred.

## Structure
- **Package `riscv_ctrl_pkg`:**
  - Opcode constants.
  - ImmSel encodings (IMM_I/IMM_S/IMM_U).
  - ALUSel encodings (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASSB 1111).
  - State enum.
- **Sub-module `riscv_ctrl_decode`:** purely combinational; maps `inst` to {ImmSel, Bsel, ALUSel, WBSel, is_load, is_store, writes_rd, is_sys, illegal}. The FSM registers its outputs in DECODE.

## Test plan
- **Reset:** `rst`=1 with `RESET_PC`=0x100 → `pc`=0x100, `imem_req`=0, `RegWEn`=`MemRW`=0. After release with `run`=1 → `imem_req`=1 next cycle.
- **ALU immediate:** addi x1,x0,5 (0x00500093), ack after 2 wait cycles → EXEC shows ImmSel=00, Bsel=1, ALUSel=0000, WBSel=1, RegWEn=1 for exactly one cycle; `pc` 0x100→0x104.
- **Register ALU:** sub x3,x1,x2 (0x402081B3) → ALUSel=1000, Bsel=0, RegWEn=1 one cycle, MemRW=0.
- **Store:** sw x2,8(x1) (0x0020A423) → ImmSel=01, Bsel=1, MemRW=1 one cycle, RegWEn=0 throughout.
- **Load:** lw x5,4(x1) (0x0040A283) → EXEC with RegWEn=0, then MEM with RegWEn=1, WBSel=0. Next `imem_req` comes 4 cycles after the ack.
- **Halt and trap:**
  - 0x00000000 → `trap`=1, `halted`=1, `pc` unchanged, no `imem_req` until `rst`.
  - 0x00000073 → `halted`=1, `trap`=0.
  - With `RISCV_CTRL_PERF_EN`, `instret_cnt` is unchanged by both.
